// File: rtl/frv_bitdep_pkg.sv
// Shared constants and types for the bit compress/decompress unit.
// Holds datapath width, latched-op encoding and FSM state type.
package frv_bitdep_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned XL    = XLEN - 1;
    localparam int unsigned CNT_W = 6;

    // Encoding of the operation latched at start
    typedef enum logic [1:0] {
        BITDEP_OP_NONE = 2'd0,
        BITDEP_OP_BEXT = 2'd1,
        BITDEP_OP_BDEP = 2'd2
    } bitdep_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } bitdep_state_e;

    // bext has priority when both selects are raised
    function automatic bitdep_op_e bitdep_decode(input logic op_bext, input logic op_bdep);
        bitdep_op_e op;
        op = BITDEP_OP_NONE;
        if (op_bext) begin
            op = BITDEP_OP_BEXT;
        end else if (op_bdep) begin
            op = BITDEP_OP_BDEP;
        end
        return op;
    endfunction

endpackage

// File: rtl/frv_bitdep_if.sv
// Request/response bundle between the execute stage and the bitdep unit.
interface frv_bitdep_if;
    import frv_bitdep_pkg::*;

    logic          valid;
    logic          op_bext;
    logic          op_bdep;
    logic          flush;
    logic [XL:0]   rs1;
    logic [XL:0]   rs2;
    logic          ready;
    logic [XL:0]   result;

    modport master (
        output valid, op_bext, op_bdep, flush, rs1, rs2,
        input  ready, result
    );

    modport slave (
        input  valid, op_bext, op_bdep, flush, rs1, rs2,
        output ready, result
    );

endinterface

// File: rtl/frv_bitdep.sv
// Iterative bcompress/bdecompress: consumes one mask bit per cycle.
// EARLY_EXIT=0 gives data-independent latency for constant-time builds.
module frv_bitdep
    import frv_bitdep_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic           g_clk,
    input  logic           g_resetn,
    frv_bitdep_if.slave    bus
);

    bitdep_state_e   state;
    bitdep_op_e      op_q;
    logic [XL:0]     mask_sr;
    logic [XL:0]     data_sr;
    logic [XL:0]     result_q;
    logic [CNT_W-1:0] i_q;
    logic [CNT_W-1:0] j_q;
    logic            finished;

    // Early exit stops once no mask bits remain; otherwise walk all XLEN bits
    always_comb begin
        finished = 1'b0;
        if (EARLY_EXIT) begin
            finished = (mask_sr == '0);
        end else begin
            finished = (i_q == CNT_W'(XLEN));
        end
    end

    // Flush suppresses a finish landing in the same cycle
    assign bus.ready  = (state == ST_BUSY) && finished && !bus.flush;
    assign bus.result = result_q;

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state    <= ST_IDLE;
            op_q     <= BITDEP_OP_NONE;
            mask_sr  <= '0;
            data_sr  <= '0;
            result_q <= '0;
            i_q      <= '0;
            j_q      <= '0;
        end else if (bus.flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.valid) begin
                        state    <= ST_BUSY;
                        op_q     <= bitdep_decode(bus.op_bext, bus.op_bdep);
                        mask_sr  <= bus.rs2;
                        data_sr  <= bus.rs1;
                        result_q <= '0;
                        i_q      <= '0;
                        j_q      <= '0;
                    end
                end
                ST_BUSY: begin
                    if (finished) begin
                        state <= ST_IDLE;
                    end else begin
                        case (op_q)
                            BITDEP_OP_BEXT: begin
                                // gather: selected bits pack into result from bit 0 up
                                if (mask_sr[0] && (j_q < CNT_W'(XLEN))) begin
                                    result_q[j_q[4:0]] <= data_sr[0];
                                    j_q                <= j_q + CNT_W'(1);
                                end
                                data_sr <= data_sr >> 1;
                            end
                            BITDEP_OP_BDEP: begin
                                // scatter: data advances only when a mask slot consumes it
                                if (i_q < CNT_W'(XLEN)) begin
                                    result_q[i_q[4:0]] <= mask_sr[0] & data_sr[0];
                                end
                                if (mask_sr[0]) begin
                                    data_sr <= data_sr >> 1;
                                end
                            end
                            default: begin
                            end
                        endcase
                        mask_sr <= mask_sr >> 1;
                        i_q     <= i_q + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frv_bitdep.sv
// Scoreboard bench for frv_bitdep: early-exit and constant-time instances side by side.
module tb_frv_bitdep;
    import frv_bitdep_pkg::*;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    logic        g_clk;
    logic        g_resetn;
    logic        valid;
    logic        op_bext;
    logic        op_bdep;
    logic        flush;
    logic [31:0] rs1;
    logic [31:0] rs2;
    bit          hold_valid;

    int n_chk;
    int n_pass;

    exp_t q_ee[$];
    exp_t q_ct[$];

    frv_bitdep_if bus_ee ();
    frv_bitdep_if bus_ct ();

    assign bus_ee.valid   = valid;
    assign bus_ee.op_bext = op_bext;
    assign bus_ee.op_bdep = op_bdep;
    assign bus_ee.flush   = flush;
    assign bus_ee.rs1     = rs1;
    assign bus_ee.rs2     = rs2;
    assign bus_ct.valid   = valid;
    assign bus_ct.op_bext = op_bext;
    assign bus_ct.op_bdep = op_bdep;
    assign bus_ct.flush   = flush;
    assign bus_ct.rs1     = rs1;
    assign bus_ct.rs2     = rs2;

    frv_bitdep #(.EARLY_EXIT(1'b1)) u_ee (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .bus      (bus_ee)
    );

    frv_bitdep #(.EARLY_EXIT(1'b0)) u_ct (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .bus      (bus_ct)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_bext(input logic [31:0] a, input logic [31:0] m);
        logic [31:0] r;
        int k;
        r = '0;
        k = 0;
        for (int b = 0; b < 32; b++) begin
            if (m[b]) begin
                r[k] = a[b];
                k++;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] m_bdep(input logic [31:0] a, input logic [31:0] m);
        logic [31:0] r;
        int k;
        r = '0;
        k = 0;
        for (int b = 0; b < 32; b++) begin
            if (m[b]) begin
                r[b] = a[k];
                k++;
            end
        end
        return r;
    endfunction

    function automatic int m_lat_ee(input logic [31:0] m);
        int h;
        h = 0;
        for (int b = 0; b < 32; b++) begin
            if (m[b]) h = b + 1;
        end
        return h + 1;
    endfunction

    function automatic logic [31:0] m_res(input bit bx, input bit bd,
                                          input logic [31:0] a, input logic [31:0] m);
        if (bx) return m_bext(a, m);
        if (bd) return m_bdep(a, m);
        return 32'h0;
    endfunction

    task automatic idle_all();
        flush = 1'b1;
        @(negedge g_clk);
        flush = 1'b0;
    endtask

    // Issue one op to both instances and score both responses
    task automatic run_op(input string tag, input bit bx, input bit bd,
                          input logic [31:0] a, input logic [31:0] m);
        exp_t e;
        int   cyc;
        int   lat_ee;
        int   lat_ct;
        logic [31:0] res_ee;
        idle_all();
        e.res = m_res(bx, bd, a, m);
        e.lat = m_lat_ee(m);
        q_ee.push_back(e);
        e.lat = 33;
        q_ct.push_back(e);
        res_ee  = e.res;
        valid   = 1'b1;
        op_bext = bx;
        op_bdep = bd;
        rs1     = a;
        rs2     = m;
        cyc     = 0;
        lat_ee  = -1;
        lat_ct  = -1;
        repeat (36) begin
            @(negedge g_clk);
            cyc++;
            valid = 1'b0;
            if (lat_ee >= 0 && cyc == lat_ee + 1) begin
                chk({tag, "_ee_pulse"}, 32'(bus_ee.ready), 32'd0);
            end else if (bus_ee.ready && lat_ee < 0) begin
                lat_ee = cyc;
                e = q_ee.pop_front();
                chk({tag, "_ee_res"}, bus_ee.result, e.res);
                chk({tag, "_ee_lat"}, 32'(cyc), 32'(e.lat));
            end else if (bus_ee.ready) begin
                chk({tag, "_ee_extra_ready"}, 32'd1, 32'd0);
            end
            if (lat_ct >= 0 && cyc == lat_ct + 1) begin
                chk({tag, "_ct_pulse"}, 32'(bus_ct.ready), 32'd0);
            end else if (bus_ct.ready && lat_ct < 0) begin
                lat_ct = cyc;
                e = q_ct.pop_front();
                chk({tag, "_ct_res"}, bus_ct.result, e.res);
                chk({tag, "_ct_lat"}, 32'(cyc), 32'(e.lat));
            end else if (bus_ct.ready) begin
                chk({tag, "_ct_extra_ready"}, 32'd1, 32'd0);
            end
        end
        if (lat_ee < 0) begin
            chk({tag, "_ee_timeout"}, 32'd0, 32'd1);
            void'(q_ee.pop_front());
        end else begin
            chk({tag, "_ee_hold"}, bus_ee.result, res_ee);
        end
        if (lat_ct < 0) begin
            chk({tag, "_ct_timeout"}, 32'd0, 32'd1);
            void'(q_ct.pop_front());
        end
    endtask

    // Wait for the early-exit instance's next ready and score it
    task automatic wait_ee(input string tag);
        exp_t e;
        int   cyc;
        bit   got;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge g_clk);
            cyc++;
            if (!hold_valid) valid = 1'b0;
            if (bus_ee.ready) got = 1'b1;
        end
        e = q_ee.pop_front();
        if (!got) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_res"}, bus_ee.result, e.res);
            chk({tag, "_lat"}, 32'(cyc), 32'(e.lat));
        end
    endtask

    // Count ready pulses on the early-exit instance over a window
    task automatic count_ready(input int ncyc, output int hits);
        hits = 0;
        repeat (ncyc) begin
            @(negedge g_clk);
            if (bus_ee.ready) hits++;
        end
    endtask

    initial begin
        exp_t e;
        int   hits;
        n_chk      = 0;
        n_pass     = 0;
        g_resetn   = 1'b0;
        valid      = 1'b0;
        op_bext    = 1'b0;
        op_bdep    = 1'b0;
        flush      = 1'b0;
        rs1        = '0;
        rs2        = '0;
        hold_valid = 1'b0;

        repeat (3) @(negedge g_clk);
        chk("rst_ee_ready",  32'(bus_ee.ready), 32'd0);
        chk("rst_ee_result", bus_ee.result,     32'd0);
        chk("rst_ct_ready",  32'(bus_ct.ready), 32'd0);
        chk("rst_ct_result", bus_ct.result,     32'd0);
        g_resetn = 1'b1;
        @(negedge g_clk);

        run_op("bext_beef",   1'b1, 1'b0, 32'hDEADBEEF, 32'h0000FF00);
        run_op("bdep_be",     1'b0, 1'b1, 32'h000000BE, 32'h00FF0000);
        run_op("bdep_full",   1'b0, 1'b1, 32'h12345678, 32'hFFFFFFFF);
        run_op("bext_zero",   1'b1, 1'b0, 32'hCAFEF00D, 32'h00000000);
        run_op("bdep_zero",   1'b0, 1'b1, 32'hCAFEF00D, 32'h00000000);
        run_op("bext_one",    1'b1, 1'b0, 32'h00000001, 32'h00000001);
        run_op("bext_full",   1'b1, 1'b0, 32'h00000001, 32'hFFFFFFFF);
        run_op("both_ops",    1'b1, 1'b1, 32'h000000A0, 32'h000000F0);
        run_op("no_op",       1'b0, 1'b0, 32'hFFFFFFFF, 32'h000000FF);
        for (int r = 0; r < 4; r++) begin
            run_op("rnd_bext", 1'b1, 1'b0, $urandom, $urandom);
            run_op("rnd_bdep", 1'b0, 1'b1, $urandom, $urandom);
        end

        // Back-to-back: valid held through the ready cycle starts the next op
        idle_all();
        e.res = 32'h0; e.lat = 1;
        q_ee.push_back(e);
        valid = 1'b1; op_bext = 1'b1; op_bdep = 1'b0;
        rs1 = 32'h00001234; rs2 = 32'h0;
        hold_valid = 1'b1;
        wait_ee("b2b_a");
        rs1 = 32'h80000001; rs2 = 32'h80000001;
        e.res = 32'h00000003; e.lat = 33;
        q_ee.push_back(e);
        @(negedge g_clk);
        chk("b2b_pulse", 32'(bus_ee.ready), 32'd0);
        hold_valid = 1'b0;
        wait_ee("b2b_b");

        // Flush mid-bdep; next op must start from IDLE with full latency
        idle_all();
        valid = 1'b1; op_bext = 1'b0; op_bdep = 1'b1;
        rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFF0000;
        repeat (5) begin
            @(negedge g_clk);
            valid = 1'b0;
        end
        flush = 1'b1;
        #1;
        chk("flush_ready", 32'(bus_ee.ready), 32'd0);
        @(negedge g_clk);
        flush = 1'b0;
        e.res = 32'h0000F0F0; e.lat = 33;
        q_ee.push_back(e);
        valid = 1'b1; op_bext = 1'b1; op_bdep = 1'b0;
        rs1 = 32'hF0F0F0F0; rs2 = 32'hFF00FF00;
        wait_ee("post_flush");
        count_ready(36, hits);
        chk("post_flush_quiet", 32'(hits), 32'd0);

        // Reset in cycle 10 of a busy op
        idle_all();
        valid = 1'b1; op_bext = 1'b1; op_bdep = 1'b0;
        rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF;
        repeat (10) begin
            @(negedge g_clk);
            valid = 1'b0;
        end
        g_resetn = 1'b0;
        @(negedge g_clk);
        chk("midrst_ready",  32'(bus_ee.ready), 32'd0);
        chk("midrst_result", bus_ee.result,     32'd0);
        g_resetn = 1'b1;
        count_ready(40, hits);
        chk("midrst_no_ready", 32'(hits), 32'd0);
        chk("midrst_result_hold", bus_ee.result, 32'd0);

        // Flush coincident with the finishing cycle (mask 0x0F finishes in cycle 5)
        idle_all();
        valid = 1'b1; op_bext = 1'b1; op_bdep = 1'b0;
        rs1 = 32'h0000000F; rs2 = 32'h0000000F;
        repeat (4) begin
            @(negedge g_clk);
            valid = 1'b0;
        end
        @(negedge g_clk);
        flush = 1'b1;
        #1;
        chk("flush_fin_ready", 32'(bus_ee.ready), 32'd0);
        @(negedge g_clk);
        flush = 1'b0;
        count_ready(40, hits);
        chk("flush_fin_quiet", 32'(hits), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/frv_bitdep.md
Name: frv_bitdep

Overview:
- Multi-cycle bit-compress/bit-decompress unit in the execute stage, alongside the single-cycle ALU.
- Implements bext/bcompress (gather bits of rs1 selected by mask rs2 into contiguous LSBs).
- Implements the inverse, bdep/bdecompress (scatter the LSBs of rs1 into the set positions of mask rs2).
- Iterative, one mask bit per cycle. Early termination is optional; it is disabled for constant-time (crypto) builds.

Parameters:
- XLEN, 32, datapath width (from frv_common.svh; only 32 supported).
- EARLY_EXIT, 1, 1: finish when remaining mask bits are zero; 0: always process all 32 bits (data-independent latency).

Ports:
- g_clk  input  1  core clock.
- g_resetn  input  1  synchronous active-low reset.
- valid  input  1  operation request; operands and op selects stable while high.
- op_bext  input  1  select bcompress.
- op_bdep  input  1  select bdecompress.
- flush  input  1  abort current operation.
- rs1  input  32  data operand.
- rs2  input  32  mask operand.
- ready  output  1  result valid this cycle (single-cycle pulse).
- result  output  32  operation result (registered).

Behaviour:
- Reset (g_resetn low at a clock edge):
  - state=IDLE; ready=0; result=0; internal counters and shift registers cleared.
  - Reset mid-operation discards the operation; no ready is produced.
- States: IDLE, BUSY.
- IDLE with valid && !flush:
  - Load mask_sr=rs2, data_sr=rs1, result=0, i=0, j=0, op latch.
  - Go to BUSY.
- BUSY with finished=0, one step per cycle:
  - bext: if mask_sr[0], then result[j]=data_sr[0] and j++. data_sr shifts right every step.
  - bdep: result[i]=mask_sr[0]&data_sr[0]. data_sr shifts right only when mask_sr[0]=1.
  - Both ops: mask_sr shifts right, i++.
- finished:
  - EARLY_EXIT=1: mask_sr==0.
  - EARLY_EXIT=0: i==32 (6-bit counter).
- BUSY with finished=1: ready=1 combinationally from state; result holds the final value; next state IDLE.
- Latency, counting the valid cycle in IDLE as cycle 0:
  - EARLY_EXIT=1: ready in cycle h+1, where h = (index of highest set bit of rs2)+1, and h=0 for mask 0. Range 1..33.
  - EARLY_EXIT=0: ready always in cycle 33.
- Back-to-back operations: valid still high in the cycle after ready is a new request and is loaded from IDLE.
- result holds its value after ready until the next load.
- flush: synchronous; highest priority over start and step.
  - Forces IDLE; ready=0 in that cycle (suppresses a coincident finish).
  - result value after flush is don't-care.
- op_bext and op_bdep both high: bext wins.
- Neither op high: completes with result 0 and normal latency.
- Widths: j is a 6-bit counter; writes to result[j] only occur for j<32, which the algorithm guarantees.

Decomposition:
- XLEN/XL come from frv_common.svh.
- Add shared localparams to the core constants header: BITDEP_OP_BEXT/BITDEP_OP_BDEP encoding for the latched op.
- State encoding is local (1 bit).
- No sub-module: the step datapath is small and stays inline in one always block.

Test Plan:
- bext rs1=0xDEADBEEF, rs2=0x0000FF00, EARLY_EXIT=1 -> result=0x000000BE, ready in cycle 17, ready high exactly one cycle.
- bdep rs1=0x000000BE, rs2=0x00FF0000 -> result=0x00BE0000, ready in cycle 25. Second case: rs2=0xFFFFFFFF, rs1=0x12345678 -> result=0x12345678, ready in cycle 33.
- rs2=0x00000000, either op -> result=0, ready in cycle 1. Then bext rs1=0x80000001, rs2=0x80000001 issued back-to-back -> result=0x00000003, ready in cycle 33.
- EARLY_EXIT=0: bext rs1=0x1, rs2=0x1 -> result=0x1, ready in cycle 33 exactly. Repeat with rs2=0xFFFFFFFF -> ready also in cycle 33.
- flush asserted in cycle 5 of bdep with rs2=0xFFFF0000 -> no ready ever for that op, state IDLE next cycle. Following bext rs1=0xF0F0F0F0, rs2=0xFF00FF00 -> result=0x0000F0F0.
- g_resetn low in cycle 10 of a busy op -> next cycle ready=0, result=0, IDLE. flush coincident with the finishing cycle -> ready stays 0.
